// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: controller states,
// default address-field geometry and line width.
package dcache_defs;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCompare   = 2'd1,
    StWriteback = 2'd2,
    StAllocate  = 2'd3
  } state_e;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_OFF_W     = 2;
  localparam int unsigned DEF_NUM_SETS   = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;

  // Address split for the default geometry: offset = addr[3:2], index = addr[7:4], tag = addr[31:8]
  localparam int unsigned OFF_W   = $clog2(DEF_LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(DEF_NUM_SETS);
  localparam int unsigned TAG_W   = WORD_W - BYTE_OFF_W - IDX_W - OFF_W;
  localparam int unsigned OFF_LSB = BYTE_OFF_W;
  localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned LINE_W  = WORD_W * DEF_LINE_WORDS;

  function automatic int unsigned line_width(input int unsigned words);
    return WORD_W * words;
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side request/response bundle of the data cache.
interface dcache_responder_if;
  import dcache_defs::*;

  logic              is_input_valid;
  logic [WORD_W-1:0] addr;
  logic              mem_rw;
  logic [WORD_W-1:0] din;
  logic              is_ready;
  logic              is_output_valid;
  logic [WORD_W-1:0] dout;
  logic              is_hit;
  logic [WORD_W-1:0] num_hits;
  logic [WORD_W-1:0] num_misses;

  modport master (
    output is_input_valid, addr, mem_rw, din,
    input  is_ready, is_output_valid, dout, is_hit, num_hits, num_misses
  );

  modport slave (
    input  is_input_valid, addr, mem_rw, din,
    output is_ready, is_output_valid, dout, is_hit, num_hits, num_misses
  );
endinterface

// File: rtl/dcache_backing_mem.sv
// Line-wide backing store: combinational read, clocked write. No reset; contents persist.
module dcache_backing_mem #(
  parameter int unsigned LINES  = 1024,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [LINES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with fixed-latency backing memory.
// Lookup happens on the accept edge so every CPU-facing output comes straight from a flop.
module dcache_responder
  import dcache_defs::*;
#(
  parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned MEM_LINES   = 1024
) (
  input logic               clk,
  input logic               reset,
  dcache_responder_if.slave bus
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(NUM_SETS);
  localparam int unsigned AddrW = WORD_W - BYTE_OFF_W;
  localparam int unsigned TagW  = AddrW - IdxW - OffW;
  localparam int unsigned LineW = line_width(LINE_WORDS);
  localparam int unsigned MemAw = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(MEM_LATENCY - 1);

  state_e            state_q;
  logic [AddrW-1:0]  addr_q;
  logic              rw_q;
  logic [WORD_W-1:0] din_q;
  logic [CntW-1:0]   cnt_q;
  logic              miss_q;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic              out_valid_q, hit_q;
  logic [WORD_W-1:0] dout_q, hits_q, misses_q;
  logic [TagW-1:0]   tag_q  [NUM_SETS];
  logic [LineW-1:0]  data_q [NUM_SETS];

  logic              idle, accept, lookup_hit, fill_done, wb_done, data_we;
  logic [AddrW-1:0]  cur_addr;
  logic              cur_rw;
  logic [WORD_W-1:0] cur_din, rd_word;
  logic [OffW-1:0]   cur_off;
  logic [IdxW-1:0]   cur_idx;
  logic [TagW-1:0]   cur_tag;
  logic [LineW-1:0]  victim_line, line_wdata, mem_rdata;
  logic [MemAw-1:0]  mem_raddr, mem_waddr;
  logic              unused_addr;

  // Backing line number {tag, index}, wrapped onto the available backing lines
  function automatic logic [MemAw-1:0] mem_line(input logic [TagW-1:0] tag,
                                                input logic [IdxW-1:0] idx);
    logic [WORD_W-1:0] full;
    full = WORD_W'({tag, idx});
    return MemAw'(full % MEM_LINES);
  endfunction

  assign idle        = (state_q == StIdle);
  assign accept      = idle && bus.is_input_valid;
  // In IDLE the live request is looked up; afterwards the latched one
  assign cur_addr    = idle ? bus.addr[WORD_W-1:BYTE_OFF_W] : addr_q;
  assign cur_rw      = idle ? bus.mem_rw : rw_q;
  assign cur_din     = idle ? bus.din : din_q;
  assign cur_off     = cur_addr[OffW-1:0];
  assign cur_idx     = cur_addr[OffW +: IdxW];
  assign cur_tag     = cur_addr[AddrW-1 -: TagW];
  assign unused_addr = ^bus.addr[BYTE_OFF_W-1:0];

  assign victim_line = data_q[cur_idx];
  assign lookup_hit  = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign fill_done   = (state_q == StAllocate) && (cnt_q == '0);
  assign wb_done     = (state_q == StWriteback) && (cnt_q == '0);
  assign data_we     = (accept && lookup_hit && cur_rw) || fill_done;
  assign mem_raddr   = mem_line(cur_tag, cur_idx);
  assign mem_waddr   = mem_line(tag_q[cur_idx], cur_idx);

  // A store is merged into the fetched line so the fill edge also completes the request
  always_comb begin
    line_wdata = fill_done ? mem_rdata : victim_line;
    if (cur_rw) begin
      line_wdata[WORD_W*cur_off +: WORD_W] = cur_din;
    end
    rd_word = line_wdata[WORD_W*cur_off +: WORD_W];
  end

  dcache_backing_mem #(
    .LINES  (MEM_LINES),
    .LINE_W (LineW),
    .ADDR_W (MemAw)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wb_done),
    .waddr_i (mem_waddr),
    .wdata_i (victim_line),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[cur_idx] <= line_wdata;
    end
    if (fill_done) begin
      tag_q[cur_idx] <= cur_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      din_q       <= '0;
      cnt_q       <= '0;
      miss_q      <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      dout_q      <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= cur_addr;
            rw_q    <= cur_rw;
            din_q   <= cur_din;
            state_q <= StCompare;
            if (lookup_hit) begin
              out_valid_q <= 1'b1;
              hit_q       <= 1'b1;
              hits_q      <= hits_q + 32'd1;
              if (cur_rw) begin
                dirty_q[cur_idx] <= 1'b1;
              end else begin
                dout_q <= rd_word;
              end
            end
          end
        end
        StCompare: begin
          // A pulse already issued means this request is done
          if (out_valid_q) begin
            miss_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            miss_q  <= 1'b1;
            cnt_q   <= CntReload;
            state_q <= (valid_q[cur_idx] && dirty_q[cur_idx]) ? StWriteback : StAllocate;
          end
        end
        StWriteback: begin
          if (cnt_q == '0) begin
            cnt_q   <= CntReload;
            state_q <= StAllocate;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAllocate: begin
          if (cnt_q == '0) begin
            valid_q[cur_idx] <= 1'b1;
            dirty_q[cur_idx] <= rw_q;
            out_valid_q      <= 1'b1;
            hit_q            <= ~miss_q;
            misses_q         <= misses_q + 32'd1;
            if (!rw_q) begin
              dout_q <= rd_word;
            end
            state_q <= StCompare;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.is_ready        = idle;
  assign bus.is_output_valid = out_valid_q;
  assign bus.dout            = dout_q;
  assign bus.is_hit          = hit_q;
  assign bus.num_hits        = hits_q;
  assign bus.num_misses      = misses_q;

endmodule
